lock_display_ctrl: RTL and testbench

- Registered, parametrised seven-segment and RGB status controller for the digital lock.
- Replaces the fixed 8-digit combinational decoder.
- Adds the following behaviour:
  - a blinking entry cursor with masked entered digits;
  - a timed "OPEN" banner that falls back to showing the passcode;
  - a blinking alarm banner.
- Sits between the lock FSM (mode, cursor position, passcode) and the board display/LED pins.

---
 rtl/lock_display_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_lock_display_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_display_ctrl.sv
// Registered seven-segment / RGB status controller for the digital lock; 2-cycle input-to-output latency.
// No backpressure: display pins update every cycle. Optional leading-zero blanking via LOCK_DISP_LZB_EN.
module lock_display_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int BLINK_HALF  = 50,
    parameter int HOLD_CYCLES = 300
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [$clog2(NUM_DIGITS):0]   pos,
    input  logic [4*NUM_DIGITS-1:0]       seq,
    output logic [8*NUM_DIGITS-1:0]       ss,
    output logic                          red,
    output logic                          green,
    output logic                          blue,
    output logic                          open_done
);

    localparam int PW = $clog2(NUM_DIGITS) + 1;
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int ALARM_DIGITS = (NUM_DIGITS < 8) ? NUM_DIGITS : 8;

    if (NUM_DIGITS < 4 || NUM_DIGITS > 16 || BLINK_HALF < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("lock_display_ctrl: illegal parameter value");
    end

    localparam logic [1:0] M_ENTRY = 2'd0;
    localparam logic [1:0] M_OPEN  = 2'd1;
    localparam logic [1:0] M_ALARM = 2'd2;

    localparam logic [2:0] S_ENTRY    = 3'd0;
    localparam logic [2:0] S_OPEN_MSG = 3'd1;
    localparam logic [2:0] S_OPEN_SEQ = 3'd2;
    localparam logic [2:0] S_ALARM    = 3'd3;
    localparam logic [2:0] S_SHOW     = 3'd4;

    localparam logic [7:0]  SEG_DASH     = 8'h40;
    localparam logic [7:0]  SEG_DP       = 8'h80;
    localparam logic [31:0] OPEN_BANNER  = 32'h3F73_7937;
    localparam logic [63:0] ALARM_BANNER = 64'h3977_3838_0067_0606;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    logic [1:0]              mode_q;
    logic [PW-1:0]           pos_q, pos_d;
    logic [4*NUM_DIGITS-1:0] seq_q, seq_d;
    logic [2:0]              state_q, state_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    first_q, first_d;

    logic [8*NUM_DIGITS-1:0] ss_q, ss_d;
    logic                    red_q, red_d;
    logic                    green_q, green_d;
    logic                    blue_q, blue_d;
    logic                    open_done_q, open_done_d;

    logic [8*NUM_DIGITS-1:0] dec_seq;
    logic                    lead_zero;

    assign pos_d = pos;
    assign seq_d = seq;

    // Mode changes win over every in-state event, including hold expiry.
    always_comb begin
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        hold_d      = hold_q;
        first_d     = first_q;
        if (mode != mode_q) begin
            case (mode)
                M_ENTRY: state_d = S_ENTRY;
                M_OPEN:  state_d = S_OPEN_MSG;
                M_ALARM: state_d = S_ALARM;
                default: state_d = S_SHOW;
            endcase
            blink_cnt_d = '0;
            phase_d     = 1'b1;
            hold_d      = '0;
            first_d     = 1'b0;
        end else begin
            case (state_q)
                S_ENTRY, S_ALARM: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                S_OPEN_MSG: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_OPEN_SEQ;
                        hold_d  = '0;
                        first_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_OPEN_SEQ: first_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        dec_seq   = '0;
        lead_zero = 1'b1;
`ifdef LOCK_DISP_LZB_EN
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead_zero && (seq_q[4*i +: 4] == 4'h0)) begin
                dec_seq[8*i +: 8] = 8'h00;
            end else begin
                lead_zero         = 1'b0;
                dec_seq[8*i +: 8] = hex_seg(seq_q[4*i +: 4]);
            end
        end
        dec_seq[7:0] = hex_seg(seq_q[3:0]);
`else
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dec_seq[8*i +: 8] = hex_seg(seq_q[4*i +: 4]);
        end
`endif
    end

    always_comb begin
        ss_d        = '0;
        red_d       = 1'b0;
        green_d     = 1'b0;
        blue_d      = 1'b0;
        open_done_d = 1'b0;
        case (state_q)
            S_ENTRY: begin
                blue_d = 1'b1;
                // pos counts from the left; digit i sits NUM_DIGITS-1-i places from the left.
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (pos_q >= PW'(NUM_DIGITS) || pos_q > PW'(NUM_DIGITS - 1 - i)) begin
                        ss_d[8*i +: 8] = SEG_DASH;
                    end else if (pos_q == PW'(NUM_DIGITS - 1 - i)) begin
                        ss_d[8*i +: 8] = phase_q ? SEG_DP : 8'h00;
                    end
                end
            end
            S_OPEN_MSG: begin
                green_d    = 1'b1;
                ss_d[31:0] = OPEN_BANNER;
            end
            S_OPEN_SEQ: begin
                green_d     = 1'b1;
                open_done_d = first_q;
                ss_d        = dec_seq;
            end
            S_ALARM: begin
                red_d = 1'b1;
                if (phase_q) begin
                    for (int i = 0; i < ALARM_DIGITS; i++) begin
                        ss_d[8*i +: 8] = ALARM_BANNER[8*i +: 8];
                    end
                end
            end
            S_SHOW: ss_d = dec_seq;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= 2'd0;
            pos_q       <= '0;
            seq_q       <= '0;
            state_q     <= S_ENTRY;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            hold_q      <= '0;
            first_q     <= 1'b0;
            ss_q        <= '0;
            red_q       <= 1'b0;
            green_q     <= 1'b0;
            blue_q      <= 1'b0;
            open_done_q <= 1'b0;
        end else begin
            mode_q      <= mode;
            pos_q       <= pos_d;
            seq_q       <= seq_d;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            first_q     <= first_d;
            ss_q        <= ss_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            open_done_q <= open_done_d;
        end
    end

    assign ss        = ss_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign open_done = open_done_q;

endmodule

// File: tb/tb_lock_display_ctrl.sv
// Bench for lock_display_ctrl: fixed vector table, random traffic against a timeline model, and corner sequences.
module tb_lock_display_ctrl;

    localparam int ND = 8;
    localparam int BH = 4;
    localparam int HC = 5;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  mode_i;
    logic [3:0]  pos_i;
    logic [31:0] seq_i;
    logic [63:0] ss;
    logic        red, green, blue, open_done;

    lock_display_ctrl #(.NUM_DIGITS(ND), .BLINK_HALF(BH), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst(rst_i), .mode(mode_i), .pos(pos_i), .seq(seq_i),
        .ss(ss), .red(red), .green(green), .blue(blue), .open_done(open_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic [3:0]  pos;
        logic [63:0] ss;
        logic [3:0]  leds;
    } vec_t;

    vec_t tab[$];
    int n_vec = 0;
    int n_err = 0;

    logic [7:0] segtab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Model: the display is a function of the latched mode and how long it has been held.
    int          m_mode, m_age, m_pos;
    logic [31:0] m_seq;

    function automatic logic [63:0] decode(input logic [31:0] sq);
        logic [63:0] s;
        int top;
        s = '0;
        top = 0;
        for (int i = 0; i < ND; i++) if (sq[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < ND; i++) begin
`ifdef LOCK_DISP_LZB_EN
            if (i <= top) s[8*i +: 8] = segtab[sq[4*i +: 4]];
`else
            s[8*i +: 8] = segtab[sq[4*i +: 4]];
`endif
        end
        return s;
    endfunction

    function automatic logic [67:0] model_out(input int md, input int age, input int p, input logic [31:0] sq);
        logic [63:0] s;
        logic [3:0]  l;
        bit          on;
        s  = '0;
        l  = 4'b0000;
        on = ((age / BH) % 2) == 0;
        case (md)
            0: begin
                l = 4'b0010;
                for (int i = 0; i < ND; i++) begin
                    int left;
                    left = ND - 1 - i;
                    if (p >= ND || left < p) s[8*i +: 8] = 8'h40;
                    else if (left == p)      s[8*i +: 8] = on ? 8'h80 : 8'h00;
                end
            end
            1: begin
                l = 4'b0100;
                if (age < HC) s[31:0] = 32'h3F737937;
                else s = decode(sq);
                if (age == HC) l = 4'b0101;
            end
            2: begin
                l = 4'b1000;
                if (on) s = 64'h39773838_00670606;
            end
            default: s = decode(sq);
        endcase
        return {s, l};
    endfunction

    // One clock: model samples the same inputs the DUT sees at the edge; outputs read 1ns later.
    task automatic step(output logic [67:0] exp_v);
        @(posedge clk);
        if (rst_i) begin
            exp_v  = '0;
            m_mode = 0; m_age = 0; m_pos = 0; m_seq = '0;
        end else begin
            exp_v = model_out(m_mode, m_age, m_pos, m_seq);
            if (int'(mode_i) != m_mode) begin
                m_mode = int'(mode_i);
                m_age  = 0;
            end else begin
                m_age++;
            end
            m_pos = int'(pos_i);
            m_seq = seq_i;
        end
        #1;
    endtask

    task automatic check(input string name, input logic [67:0] exp_v);
        logic [67:0] act;
        act = {ss, red, green, blue, open_done};
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got ss=%h rgbd=%b, want ss=%h rgbd=%b",
                     name, act[67:4], act[3:0], exp_v[67:4], exp_v[3:0]);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] m, input logic [63:0] s, input logic [3:0] l);
        vec_t v;
        v.rst = r; v.mode = m; v.pos = 4'd2; v.ss = s; v.leds = l;
        tab.push_back(v);
    endtask

    localparam logic [63:0] P0_ON  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] P2_ON  = 64'h4040_8000_0000_0000;
    localparam logic [63:0] P2_OFF = 64'h4040_0000_0000_0000;
    localparam logic [63:0] BAN    = 64'h0000_0000_3F73_7937;
    localparam logic [63:0] SEQD   = 64'h065B_4F66_777C_395E;
    localparam logic [63:0] ALRM   = 64'h3977_3838_0067_0606;

    initial begin
        logic [67:0] e;
        rst_i = 1'b1; mode_i = 2'd0; pos_i = 4'd2; seq_i = 32'h1234ABCD;
        m_mode = 0; m_age = 0; m_pos = 0; m_seq = '0;

        add(1, 0, 64'h0, 4'b0000);
        add(1, 0, 64'h0, 4'b0000);
        add(0, 0, P0_ON, 4'b0010);
        for (int k = 0; k < 3; k++) add(0, 0, P2_ON, 4'b0010);
        for (int k = 0; k < 4; k++) add(0, 0, P2_OFF, 4'b0010);
        add(0, 0, P2_ON, 4'b0010);
        add(0, 1, P2_ON, 4'b0010);
        for (int k = 0; k < 5; k++) add(0, 1, BAN, 4'b0100);
        add(0, 1, SEQD, 4'b0101);
        add(0, 1, SEQD, 4'b0100);
        add(0, 1, SEQD, 4'b0100);
        add(0, 2, SEQD, 4'b0100);
        for (int k = 0; k < 4; k++) add(0, 2, ALRM, 4'b1000);
        for (int k = 0; k < 4; k++) add(0, 2, 64'h0, 4'b1000);
        add(0, 2, ALRM, 4'b1000);
        add(0, 1, ALRM, 4'b1000);
        for (int k = 0; k < 4; k++) add(0, 1, BAN, 4'b0100);
        add(0, 0, BAN, 4'b0100);
        add(0, 0, P2_ON, 4'b0010);
        add(0, 0, P2_ON, 4'b0010);
        add(0, 1, P2_ON, 4'b0010);
        add(0, 1, BAN, 4'b0100);
        add(1, 1, 64'h0, 4'b0000);
        add(0, 1, P0_ON, 4'b0010);
        add(0, 1, BAN, 4'b0100);

        foreach (tab[k]) begin
            rst_i = tab[k].rst; mode_i = tab[k].mode; pos_i = tab[k].pos;
            step(e);
            check($sformatf("table[%0d]", k), {tab[k].ss, tab[k].leds});
        end

        for (int c = 0; c < 1500; c++) begin
            rst_i = ($urandom_range(299) == 0);
            if ($urandom_range(11) == 0) mode_i = 2'($urandom_range(3));
            if ($urandom_range(7) == 0)  pos_i  = 4'($urandom_range(15));
            if ($urandom_range(5) == 0)  seq_i  = ($urandom_range(1) == 0) ? $urandom : ($urandom & 32'h0000_0F0F);
            step(e);
            check($sformatf("random[%0d]", c), e);
        end

        rst_i = 1'b0; mode_i = 2'd3; seq_i = 32'h0000_0A05;
        for (int k = 0; k < 3; k++) begin
            step(e);
            check("show_seq", e);
        end
`ifdef LOCK_DISP_LZB_EN
        check("show_lzb", {64'h0000_0000_0077_3F6D, 4'b0000});
`else
        check("show_full", {64'h3F3F_3F3F_3F77_3F6D, 4'b0000});
`endif

        mode_i = 2'd0; pos_i = 4'd9;
        for (int k = 0; k < 3; k++) begin
            step(e);
            check("entry_pos_over", e);
        end
        check("entry_all_dash", {64'h4040_4040_4040_4040, 4'b0010});

        mode_i = 2'd1;
        for (int k = 0; k < 8; k++) begin
            step(e);
            check("open_leave_late", e);
            if (k == 6) mode_i = 2'd2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
